// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage, instruction memory and the IF/ID register.
// Handshakes: imem_req/imem_addr stay asserted and stable until the single-cycle
// imem_ack, which also qualifies imem_rdata. Downstream, inst_valid marks
// pc_out/instruction as meaningful and the consumer takes them on a clock
// where stall=0. While stall=1, all three are held.
interface instr_fetch_if;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [7:0]  pc_out;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        halted;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata, imem_ack,
        output imem_req, imem_addr, pc_out, instruction, inst_valid, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata, imem_ack,
        input  imem_req, imem_addr, pc_out, instruction, inst_valid, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time, and
// presents it to IF/ID. A one-entry skid buffer absorbs an ack that arrives
// while the output is stalled. Branch redirects flush the output and the skid.
// A HALT opcode stops all further fetching until reset.
module instr_fetch #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter logic [31:0] NOP         = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     bus,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  pc;
    logic [7:0]  drain_addr;
    logic [7:0]  pc_out_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        halted_q;
    logic        skid_valid;
    logic [7:0]  skid_pc;
    logic [31:0] skid_data;

    logic        fetch_ack;
    logic        is_halt;
    logic        out_free;
    logic        skid_release;
    logic        redirect_ok;

    // HALT is the only state that ignores redirect; only a real fetch ack (not a
    // drained one) carries an instruction worth keeping.
    assign redirect_ok  = bus.redirect && (state != HALT);
    assign fetch_ack    = (state == REQ) && bus.imem_ack;
    assign is_halt      = (bus.imem_rdata[31:26] == HALT_OPCODE);
    assign out_free     = !valid_q || !bus.stall;
    assign skid_release = skid_valid && !bus.stall;

    assign bus.pc_out      = pc_out_q;
    assign bus.instruction = instr_q;
    assign bus.inst_valid  = valid_q;
    assign bus.halted      = halted_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; redirect outranks ack and stall.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                if (bus.redirect)      state_nxt = bus.imem_ack ? REQ : DRAIN;
                else if (bus.imem_ack) state_nxt = is_halt ? HALT : (out_free ? REQ : HOLD);
            end
            HOLD:  if (bus.redirect || !bus.stall) state_nxt = REQ;
            DRAIN: if (bus.imem_ack) state_nxt = REQ;
            HALT:  state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request outputs; DRAIN keeps presenting the abandoned address.
    always_comb begin
        bus.imem_req  = (state == REQ) || (state == DRAIN);
        bus.imem_addr = (state == DRAIN) ? drain_addr : pc;
        state_dbg     = state;
    end

    // PC, output registers and skid buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            pc_out_q   <= 8'h00;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= 8'h00;
            skid_data  <= NOP;
        end else if (redirect_ok) begin
            pc         <= bus.redirect_pc;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            skid_valid <= 1'b0;
            if (state == REQ && !bus.imem_ack) drain_addr <= pc;
        end else if (fetch_ack) begin
            if (out_free) begin
                pc_out_q <= pc;
                instr_q  <= bus.imem_rdata;
                valid_q  <= 1'b1;
            end else begin
                skid_pc    <= pc;
                skid_data  <= bus.imem_rdata;
                skid_valid <= 1'b1;
            end
            if (is_halt) halted_q <= 1'b1;
            else         pc       <= pc + 8'd1;
        end else if (skid_release) begin
            pc_out_q   <= skid_pc;
            instr_q    <= skid_data;
            valid_q    <= 1'b1;
            skid_valid <= 1'b0;
        end else if (!bus.stall) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table for stall/skid/redirect corners, hand
// sequences for reset-in-HOLD and HALT, and a memory responder feeding a
// scoreboard for streaming fetch with PC wrap and random stalls.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state_dbg;

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC   (8'h00),
        .HALT_OPCODE(6'h3F),
        .NOP        (32'h0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.master),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_HOLD = 3'd2, S_DRAIN = 3'd3, S_HALT = 3'd4;
    localparam logic [31:0] DA = 32'h0400_00A1, DB = 32'h0800_00B2, DC = 32'h0C00_00C3;
    localparam logic [31:0] DD = 32'h1000_00D4, DE = 32'h1400_00E5, DF = 32'h1800_00F6;

    int checks = 0;
    int errors = 0;
    int deliv  = 0;
    int cyc;

    logic [39:0] exp_q[$];
    logic [39:0] sb_e;
    logic [7:0]  nxt_pc;
    logic        auto_mem = 1'b0;
    logic        sb_on    = 1'b0;
    logic        rand_lat = 1'b0;
    logic        halt_en  = 1'b0;
    logic [7:0]  halt_addr = 8'h0A;
    int          mem_lat  = 1;
    int          mem_cnt  = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [7:0]  rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [7:0]  addr;
        logic        valid;
        logic [7:0]  pc_out;
        logic [31:0] instr;
        logic [2:0]  st;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        if (halt_en && a == halt_addr) return {6'h3F, 2'b00, a, 16'hC0DE};
        return {2'b01, a[3:0], 2'b10, a, 8'hA5, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00;
        if (!auto_mem) begin
            bus.imem_ack = 1'b0;
            bus.imem_rdata = 32'h0;
        end
        exp_q.delete();
        nxt_pc = 8'h00;
        deliv = 0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Memory model: acks mem_lat cycles after a request first appears.
    always begin
        @(posedge clk);
        #3;
        if (auto_mem) begin
            if (!reset) begin
                bus.imem_ack = 1'b0;
                mem_cnt = 0;
            end else begin
                if (bus.imem_ack) begin
                    bus.imem_ack = 1'b0;
                    mem_cnt = 0;
                end
                if (bus.imem_req) begin
                    mem_cnt++;
                    if (mem_cnt > mem_lat) begin
                        bus.imem_ack = 1'b1;
                        bus.imem_rdata = mem_word(bus.imem_addr);
                        chk("req_addr", 32'(bus.imem_addr), 32'(nxt_pc));
                        exp_q.push_back({bus.imem_addr, bus.imem_rdata});
                        nxt_pc = bus.imem_addr + 8'd1;
                        if (rand_lat) mem_lat = $urandom_range(0, 2);
                    end
                end
            end
        end
    end

    // Scoreboard: every instruction accepted downstream must match the queue head.
    always begin
        @(negedge clk);
        if (sb_on && reset && bus.inst_valid && !bus.stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc %h instr %h expected nothing", bus.pc_out, bus.instruction);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", 32'(bus.pc_out), 32'(sb_e[39:32]));
                chk("sb_instr", bus.instruction, sb_e[31:0]);
                deliv++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;

        //            stall redir rpc    ack rdata          req addr   vld pc_out instr st
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 8'h00, 32'h0, S_IDLE};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, DA,           1'b1, 8'h00, 1'b0, 8'h00, 32'h0, S_REQ};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h01, 1'b1, 8'h00, DA,    S_REQ};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, DB,           1'b1, 8'h01, 1'b1, 8'h00, DA,    S_REQ};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h02, 1'b1, 8'h00, DA,    S_HOLD};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h02, 1'b1, 8'h00, DA,    S_HOLD};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h02, 1'b1, 8'h01, DB,    S_REQ};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, DC,           1'b1, 8'h02, 1'b0, 8'h01, 32'h0, S_REQ};
        tbl[8]  = '{1'b0, 1'b1, 8'h40, 1'b0, 32'h0,        1'b1, 8'h03, 1'b1, 8'h02, DC,    S_REQ};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h03, 1'b0, 8'h02, 32'h0, S_DRAIN};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h03, 1'b0, 8'h02, 32'h0, S_DRAIN};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, DD,           1'b1, 8'h03, 1'b0, 8'h02, 32'h0, S_DRAIN};
        tbl[12] = '{1'b0, 1'b1, 8'h80, 1'b1, DE,           1'b1, 8'h40, 1'b0, 8'h02, 32'h0, S_REQ};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, DF,           1'b1, 8'h80, 1'b0, 8'h02, 32'h0, S_REQ};
        tbl[14] = '{1'b1, 1'b1, 8'h10, 1'b0, 32'h0,        1'b1, 8'h81, 1'b1, 8'h80, DF,    S_REQ};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b1, 8'h81, 1'b0, 8'h80, 32'h0, S_DRAIN};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h10, 1'b0, 8'h80, 32'h0, S_REQ};

        // Cycle table: reset state, stall+skid, redirect with/without ack.
        step();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.stall       = tbl[i].stall;
            bus.redirect    = tbl[i].redirect;
            bus.redirect_pc = tbl[i].rpc;
            bus.imem_ack    = tbl[i].ack;
            bus.imem_rdata  = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("t%0d_req", i),    32'(bus.imem_req),   32'(tbl[i].req));
            chk($sformatf("t%0d_addr", i),   32'(bus.imem_addr),  32'(tbl[i].addr));
            chk($sformatf("t%0d_valid", i),  32'(bus.inst_valid), 32'(tbl[i].valid));
            chk($sformatf("t%0d_pc_out", i), 32'(bus.pc_out),     32'(tbl[i].pc_out));
            chk($sformatf("t%0d_instr", i),  bus.instruction,     tbl[i].instr);
            chk($sformatf("t%0d_state", i),  32'(state_dbg),      32'(tbl[i].st));
            chk($sformatf("t%0d_halted", i), 32'(bus.halted),     32'h0);
            step();
        end
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;

        // Reset while HOLD has a full skid.
        do_reset();
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = DA;
        step();
        bus.stall = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = DB;
        step();
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("rh_state_hold", 32'(state_dbg), 32'(S_HOLD));
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.stall = 1'b0;
        @(negedge clk);
        chk("rh_valid", 32'(bus.inst_valid), 32'h0);
        chk("rh_instr", bus.instruction, 32'h0);
        chk("rh_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rh_req", 32'(bus.imem_req), 32'h0);
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = DC;
        @(negedge clk);
        chk("rh_req2", 32'(bus.imem_req), 32'h1);
        chk("rh_addr2", 32'(bus.imem_addr), 32'h00);
        step();
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("rh_out_pc", 32'(bus.pc_out), 32'h00);
        chk("rh_out_instr", bus.instruction, DC);
        step();
        @(negedge clk);
        chk("rh_no_skid", 32'(bus.inst_valid), 32'h0);
        step();

        // HALT at 0A: delivered, then no more requests and redirect ignored.
        auto_mem = 1'b1;
        sb_on = 1'b1;
        halt_en = 1'b1;
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 100 && !bus.halted; i++) @(negedge clk);
        chk("halt_seen", 32'(bus.halted), 32'h1);
        chk("halt_valid", 32'(bus.inst_valid), 32'h1);
        chk("halt_pc", 32'(bus.pc_out), 32'h0A);
        chk("halt_instr", bus.instruction, mem_word(8'h0A));
        chk("halt_req", 32'(bus.imem_req), 32'h0);
        step();
        for (int i = 0; i < 6; i++) begin
            bus.redirect = 1'b1;
            bus.redirect_pc = 8'h40;
            @(negedge clk);
            chk("halt_req_off", 32'(bus.imem_req), 32'h0);
            chk("halt_state", 32'(state_dbg), 32'(S_HALT));
            step();
        end
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("halt_stuck", 32'(bus.halted), 32'h1);
        chk("halt_drained", 32'(bus.inst_valid), 32'h0);
        chk("halt_count", 32'(deliv), 32'd11);
        chk("halt_q_empty", 32'(exp_q.size()), 32'h0);
        step();

        // Streaming fetch through the FF->00 wrap at peak rate.
        halt_en = 1'b0;
        do_reset();
        cyc = 0;
        while (deliv < 260 && cyc < 1000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("stream_count", 32'(deliv >= 260), 32'h1);
        chk("stream_rate", 32'(cyc <= 525), 32'h1);
        step();

        // Random stalls and memory latency.
        rand_lat = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bus.stall = ($urandom_range(0, 2) == 0);
            step();
        end
        bus.stall = 1'b0;
        rand_lat = 1'b0;
        mem_lat = 1;
        repeat (8) step();
        chk("rand_progress", 32'(deliv > 360), 32'h1);
        chk("rand_q_level", 32'(exp_q.size() <= 1), 32'h1);

        sb_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
